// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD timer family (countdown and up-counter).
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned BCD_MAX = 9;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Non-BCD preset digits saturate at 9.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_W'(BCD_MAX)) ? BCD_W'(BCD_MAX) : d;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running 0..DIV-1 divider producing a registered one-cycle clock-enable tick.
module tick_divider #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic sync_rst,
    output logic tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_d, div_cnt_q;
    logic          tick_d, tick_q;

    // tick_q is high exactly while div_cnt_q sits at LAST.
    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        if (sync_rst || (div_cnt_q == LAST)) begin
            div_cnt_d = '0;
        end
        tick_d = (div_cnt_d == LAST);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer (99..00) with load, start/pause/resume and a done pulse.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             start,
    input  logic [BCD_W-1:0] in_tens,
    input  logic [BCD_W-1:0] in_ones,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             running,
    output logic             done,
    output logic             tick
);

    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

    state_e           state_d, state_q;
    logic [BCD_W-1:0] tens_d, tens_q;
    logic [BCD_W-1:0] ones_d, ones_q;
    logic             done_d, done_q;
    logic             running_d, running_q;
    logic             div_rst_c;
    logic             tick_c;

    tick_divider #(.DIV(DIV)) u_div (
        .clk      (clk),
        .clr      (clr),
        .sync_rst (div_rst_c),
        .tick     (tick_c)
    );

    // Priority load > start > tick; entering RUN restarts the divider for a full first period.
    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        done_d    = 1'b0;
        div_rst_c = 1'b0;
        if (load) begin
            tens_d    = bcd_clamp(in_tens);
            ones_d    = bcd_clamp(in_ones);
            state_d   = IDLE;
            div_rst_c = 1'b1;
        end else if (start) begin
            case (state_q)
                IDLE: begin
                    if ((tens_q != '0) || (ones_q != '0)) begin
                        state_d   = RUN;
                        div_rst_c = 1'b1;
                    end
                end
                RUN:   state_d = PAUSE;
                PAUSE: begin
                    state_d   = RUN;
                    div_rst_c = 1'b1;
                end
                default: state_d = state_q;
            endcase
        end else if (tick_c && (state_q == RUN)) begin
            if (ones_q != '0) begin
                ones_d = ones_q - BCD_W'(1);
            end else if (tens_q != '0) begin
                ones_d = BCD_W'(BCD_MAX);
                tens_d = tens_q - BCD_W'(1);
            end
            if ((tens_q == '0) && (ones_q <= BCD_W'(1))) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            tens_q    <= '0;
            ones_q    <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign done    = done_q;
    assign running = running_q;
    assign tick    = tick_c;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer with CLK_HZ=4, TICK_HZ=1 (DIV=4).
module tb_bcd_countdown_timer;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       done;
        logic       running;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic [3:0] in_tens = 4'd0;
    logic [3:0] in_ones = 4'd0;
    logic [3:0] tens, ones;
    logic       running, done, tick;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];

    bcd_countdown_timer #(.CLK_HZ(4), .TICK_HZ(1)) dut (
        .clk     (clk),
        .clr     (clr),
        .load    (load),
        .start   (start),
        .in_tens (in_tens),
        .in_ones (in_ones),
        .tens    (tens),
        .ones    (ones),
        .running (running),
        .done    (done),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    // Stimulus drivers: called at a negedge, return at the negedge after the capturing edge.
    task automatic pulse_load(input logic [3:0] t, input logic [3:0] o);
        load = 1'b1; in_tens = t; in_ones = o;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({tens, ones, running, done, tick} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_state got=%h exp=000", {tens, ones, running, done, tick});
        end
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clamp_and_zero_start();
        pulse_load(4'hC, 4'hF);
        tests_run++;
        if ({tens, ones, running} !== {4'd9, 4'd9, 1'b0}) begin
            tests_failed++;
            $display("FAIL clamp got=%0d%0d run=%0b exp=99 run=0", tens, ones, running);
        end
        pulse_load(4'd0, 4'd0);
        pulse_start();
        for (int c = 0; c < 12; c++) begin
            tests_run++;
            if ({tens, ones, running, done} !== 10'd0) begin
                tests_failed++;
                $display("FAIL zero_start c=%0d got=%0d%0d run=%0b done=%0b exp=00 0 0", c, tens, ones, running, done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_countdown();
        exp_t e;
        pulse_load(4'd1, 4'd2);
        pulse_start();
        tests_run++;
        if ({tens, ones, running} !== {4'd1, 4'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL cd_start got=%0d%0d run=%0b exp=12 run=1", tens, ones, running);
        end
        for (int v = 11; v >= 0; v--)
            exp_q.push_back('{tens: 4'(v / 10), ones: 4'(v % 10), done: (v == 0), running: (v != 0)});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                tests_run++;
                if (tick !== (c == 3)) begin
                    tests_failed++;
                    $display("FAIL cd_tick c=%0d got=%0b exp=%0b", c, tick, (c == 3));
                end
                if (c < 4) begin
                    tests_run++;
                    if (done !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL cd_early_done c=%0d got=1 exp=0", c);
                    end
                end
            end
            tests_run++;
            if ({tens, ones, done, running} !== e) begin
                tests_failed++;
                $display("FAIL cd_step got=%0d%0d d=%0b r=%0b exp=%0d%0d d=%0b r=%0b",
                         tens, ones, done, running, e.tens, e.ones, e.done, e.running);
            end
        end
        @(negedge clk);
        tests_run++;
        if ({tens, ones, done, running} !== 10'd0) begin
            tests_failed++;
            $display("FAIL cd_after_done got=%0d%0d d=%0b r=%0b exp=00 d=0 r=0", tens, ones, done, running);
        end
    endtask

    task automatic test_done_hold();
        int pulses = 0;
        int where  = -1;
        for (int c = 0; c < 12; c++) begin
            start = (c % 3 == 0);
            @(negedge clk);
            start = 1'b0;
            tests_run++;
            if ({tens, ones, running, done} !== 10'd0) begin
                tests_failed++;
                $display("FAIL done_hold c=%0d got=%0d%0d r=%0b d=%0b exp=00 0 0", c, tens, ones, running, done);
            end
        end
        pulse_load(4'd0, 4'd1);
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                where = c;
            end
        end
        tests_run++;
        if (pulses != 1 || where != 4) begin
            tests_failed++;
            $display("FAIL single_done pulses=%0d at=%0d exp=1 at=4", pulses, where);
        end
        tests_run++;
        if ({tens, ones} !== 8'h00) begin
            tests_failed++;
            $display("FAIL single_done_val got=%0d%0d exp=00", tens, ones);
        end
    endtask

    task automatic test_pause_resume();
        exp_t e;
        pulse_load(4'd2, 4'd0);
        pulse_start();
        exp_q.push_back('{tens: 4'd1, ones: 4'd9, done: 1'b0, running: 1'b1});
        repeat (4) @(negedge clk);
        e = exp_q.pop_front();
        tests_run++;
        if ({tens, ones, done, running} !== e) begin
            tests_failed++;
            $display("FAIL borrow got=%0d%0d r=%0b exp=19 r=1", tens, ones, running);
        end
        pulse_start();
        for (int c = 0; c < 20; c++) begin
            tests_run++;
            if ({tens, ones, running} !== {4'd1, 4'd9, 1'b0}) begin
                tests_failed++;
                $display("FAIL pause_hold c=%0d got=%0d%0d r=%0b exp=19 r=0", c, tens, ones, running);
            end
            @(negedge clk);
        end
        pulse_start();
        exp_q.push_back('{tens: 4'd1, ones: 4'd9, done: 1'b0, running: 1'b1});
        exp_q.push_back('{tens: 4'd1, ones: 4'd9, done: 1'b0, running: 1'b1});
        exp_q.push_back('{tens: 4'd1, ones: 4'd9, done: 1'b0, running: 1'b1});
        exp_q.push_back('{tens: 4'd1, ones: 4'd8, done: 1'b0, running: 1'b1});
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({tens, ones, done, running} !== e) begin
                tests_failed++;
                $display("FAIL resume c=%0d got=%0d%0d r=%0b exp=%0d%0d r=%0b", c, tens, ones, running, e.tens, e.ones, e.running);
            end
        end
    endtask

    task automatic test_load_vs_tick();
        pulse_load(4'd0, 4'd5);
        pulse_start();
        repeat (3) @(negedge clk);
        tests_run++;
        if ({tick, tens, ones} !== {1'b1, 4'd0, 4'd5}) begin
            tests_failed++;
            $display("FAIL pre_collision got tick=%0b val=%0d%0d exp tick=1 val=05", tick, tens, ones);
        end
        pulse_load(4'd3, 4'd0);
        for (int c = 0; c < 9; c++) begin
            tests_run++;
            if ({tens, ones, running, done} !== {4'd3, 4'd0, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL load_wins c=%0d got=%0d%0d r=%0b d=%0b exp=30 0 0", c, tens, ones, running, done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clr_midrun();
        pulse_load(4'd3, 4'd7);
        pulse_start();
        @(negedge clk);
        tests_run++;
        if ({tens, ones, running} !== {4'd3, 4'd7, 1'b1}) begin
            tests_failed++;
            $display("FAIL clr_pre got=%0d%0d r=%0b exp=37 r=1", tens, ones, running);
        end
        #2 clr = 1'b1;
        #1;
        tests_run++;
        if ({tens, ones, running, done, tick} !== 11'd0) begin
            tests_failed++;
            $display("FAIL clr_async got=%h exp=000", {tens, ones, running, done, tick});
        end
        @(negedge clk);
        clr = 1'b0;
        pulse_start();
        repeat (6) @(negedge clk);
        tests_run++;
        if ({tens, ones, running, done} !== 10'd0) begin
            tests_failed++;
            $display("FAIL clr_after got=%0d%0d r=%0b d=%0b exp=00 0 0", tens, ones, running, done);
        end
    endtask

    initial begin
        test_reset();
        test_clamp_and_zero_start();
        test_countdown();
        test_done_hold();
        test_pause_resume();
        test_load_vs_tick();
        test_clr_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Two-digit BCD countdown timer, 99..00. Loads a preset, then decrements once per second.
- Asserts a one-cycle done pulse when the count reaches 00.
- Counterpart to the team's up-counting BCD counter; drives the same 7-segment display path.
- Fully synchronous on clk. The 1 Hz rate is a clock-enable tick, not a derived clock.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1, decrement rate. DIV = CLK_HZ/TICK_HZ, must be >= 2.

Ports:
- clk  input  1  system clock
- clr  input  1  reset, asynchronous, active-high
- load  input  1  synchronous preset strobe
- start  input  1  single-cycle pulse: start / pause / resume
- in_tens  input  4  preset tens digit, BCD
- in_ones  input  4  preset ones digit, BCD
- tens  output  4  current tens digit
- ones  output  4  current ones digit
- running  output  1  high while in RUN
- done  output  1  one-cycle pulse on reaching 00
- tick  output  1  one-cycle divider pulse, for debug/cascade

Behaviour:
- Reset (clr=1, any time, mid-count included):
  - tens=0, ones=0, running=0, done=0, tick=0.
  - Divider=0, state=IDLE.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps.
  - tick=1 for exactly the one cycle in which div_cnt==DIV-1.
  - div_cnt resets to 0 on load and on any start that enters RUN, so the first decrement comes a full DIV cycles later.
- States:
  - IDLE: holding preset, not counting.
  - RUN: counting down.
  - PAUSE: frozen.
  - DONE: at 00, waiting for load.
- Priority: clr > load > start > tick.
- load, any state:
  - tens <= min(in_tens, 9); ones <= min(in_ones, 9). Non-BCD inputs clamp to 9.
  - state <= IDLE. Any pending decrement that cycle is discarded.
- start:
  - IDLE with value != 00 -> RUN.
  - IDLE with value == 00 -> ignored.
  - RUN -> PAUSE.
  - PAUSE -> RUN.
  - DONE -> ignored.
- Decrement, RUN and tick=1:
  - ones != 0: ones <= ones-1.
  - ones == 0: ones <= 9, tens <= tens-1 (borrow).
  - If the pre-decrement value is 01: the result is 00, state -> DONE, and done=1 on the following cycle for exactly one cycle.
- Wrap-around: the count never wraps below 00. DONE holds 00 until load.
- start and tick in the same cycle while in RUN: the pause takes effect and that tick's decrement is discarded.
- PAUSE: tick keeps running but is ignored. Digits hold.
- running = (state==RUN), registered from state.
- Preset 00 followed by start: no done pulse, stays IDLE.

Decomposition:
- Shared package timer_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE}.
  - BCD_MAX=9.
  - Function computing DIV from CLK_HZ/TICK_HZ.
- Sub-module tick_divider:
  - Parameter DIV; inputs clk, clr, sync_rst; output tick.
  - Reusable by the up-counter rework.
- Main block holds the FSM and the BCD borrow logic.

Test Plan (CLK_HZ=4, TICK_HZ=1, so DIV=4):
1. clr pulse mid-run at value 37 -> tens=0, ones=0, running=0, done=0 in the same cycle, asynchronously.
2. load 12, start -> tens/ones go 12, 11, 10, 09, ..., 01, 00, each step 4 clk apart. done is high for 1 cycle after 00; state DONE; running=0.
3. load 20, start, wait 1 tick -> value 19 (borrow). Start again -> PAUSE, value holds 19 for 20 cycles. Start -> resumes, next value 18 after 4 cycles.
4. load in_tens=0xC, in_ones=0xF -> value 99. Load 00 then start -> stays IDLE, no done pulse.
5. RUN at value 05, load 30 asserted in the same cycle as tick -> value 30, state IDLE, no decrement applied.
6. In DONE, start pulses -> ignored, value stays 00. Load 01 then start -> after 4 cycles value 00 and a single done pulse.
